mem_ctrl: RTL and testbench

Frame sequencer for the single-clock simple dual-port pixel BRAM (`memory`) in the 2D convolution pipeline. It accepts a frame of pixels from the host-side loader over a valid/ready handshake and writes them to consecutive BRAM addresses. It then streams the frame back, in address order, to the convolution engine over a second valid/ready handshake. It hides the BRAM's one-cycle registered read latency and sustains one word per clock when the consumer does not stall.

---
 rtl/mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Frame sequencer for the pixel BRAM: loads a frame over a valid/ready handshake, then streams it back in address order.
// Optional feature: define MEM_CTRL_REPLAY_EN to add i_replay, which re-streams the stored frame without a reload.
module mem_ctrl #(
    parameter int RAM_WIDTH  = 8,
    parameter int NB_ADDRESS = 10
) (
    input  logic                  i_CLK,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [NB_ADDRESS-1:0] i_len,
`ifdef MEM_CTRL_REPLAY_EN
    input  logic                  i_replay,
`endif
    input  logic                  i_wr_valid,
    input  logic [RAM_WIDTH-1:0]  i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_rd_valid,
    output logic [RAM_WIDTH-1:0]  o_rd_data,
    input  logic                  i_rd_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_wrEnable,
    output logic [NB_ADDRESS-1:0] o_mem_writeAdd,
    output logic [NB_ADDRESS-1:0] o_mem_readAdd,
    output logic [RAM_WIDTH-1:0]  o_mem_data,
    input  logic [RAM_WIDTH-1:0]  i_mem_data
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                state_q;
    logic [NB_ADDRESS-1:0] len_q;
    logic [NB_ADDRESS-1:0] wr_cnt_q;
    logic [NB_ADDRESS-1:0] rd_cnt_q;
    logic [NB_ADDRESS-1:0] out_cnt_q;
    logic                  rd_all_q;
    logic                  inflight_q;
    logic [RAM_WIDTH-1:0]  fifo_q [2];
    logic                  wptr_q;
    logic                  rptr_q;
    logic [1:0]            occ_q;
`ifdef MEM_CTRL_REPLAY_EN
    logic                  loaded_q;
`endif

    logic wr_fire;
    logic pop;
    logic push;
    logic issue;
    logic last_out;

    assign wr_fire        = (state_q == LOAD) && i_wr_valid;
    assign o_wr_ready     = (state_q == LOAD);
    assign o_busy         = (state_q != IDLE);
    assign o_mem_wrEnable = wr_fire;
    assign o_mem_writeAdd = wr_cnt_q;
    assign o_mem_data     = wr_fire ? i_wr_data : '0;
    assign o_mem_readAdd  = rd_cnt_q;

    assign o_rd_valid = (occ_q != 2'd0);
    assign o_rd_data  = o_rd_valid ? fifo_q[rptr_q] : '0;
    assign pop        = o_rd_valid && i_rd_ready;
    assign push       = inflight_q;
    assign last_out   = pop && (out_cnt_q == len_q);
    assign o_done     = (state_q == RUN) && last_out;

    // A pop this cycle frees a slot, so counting it keeps one issue per clock in steady state.
    assign issue = (state_q == RUN) && !rd_all_q && (rd_cnt_q <= len_q) &&
                   (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

    always_ff @(posedge i_CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            rd_all_q   <= 1'b0;
            inflight_q <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            occ_q      <= 2'd0;
`ifdef MEM_CTRL_REPLAY_EN
            loaded_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q   <= LOAD;
                        len_q     <= i_len;
                        wr_cnt_q  <= '0;
                        rd_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        rd_all_q  <= 1'b0;
`ifdef MEM_CTRL_REPLAY_EN
                        loaded_q  <= 1'b0;
                    end else if (i_replay && loaded_q) begin
                        state_q   <= RUN;
                        rd_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        rd_all_q  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                        if (wr_cnt_q == len_q) begin
                            state_q  <= RUN;
`ifdef MEM_CTRL_REPLAY_EN
                            loaded_q <= 1'b1;
`endif
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                        if (rd_cnt_q == len_q) rd_all_q <= 1'b1;
                    end
                    if (pop) out_cnt_q <= out_cnt_q + 1'b1;
                    if (last_out) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            inflight_q <= issue;

            // BRAM data returns one cycle after its issue and lands in the 2-entry FIFO.
            if (push) begin
                fifo_q[wptr_q] <= i_mem_data;
                wptr_q         <= ~wptr_q;
            end
            if (pop) rptr_q <= ~rptr_q;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered-read BRAM model and an output/write monitor.
module tb_mem_ctrl;

    logic       clk;
    logic       rst_n;
    logic       i_start;
    logic [9:0] i_len;
`ifdef MEM_CTRL_REPLAY_EN
    logic       i_replay;
`endif
    logic       i_wr_valid;
    logic [7:0] i_wr_data;
    logic       o_wr_ready;
    logic       o_rd_valid;
    logic [7:0] o_rd_data;
    logic       i_rd_ready;
    logic       o_busy;
    logic       o_done;
    logic       we;
    logic [9:0] wa;
    logic [9:0] ra;
    logic [7:0] wd;
    logic [7:0] rd;

    mem_ctrl #(.RAM_WIDTH(8), .NB_ADDRESS(10)) dut (
        .i_CLK(clk), .i_rst_n(rst_n), .i_start(i_start), .i_len(i_len),
`ifdef MEM_CTRL_REPLAY_EN
        .i_replay(i_replay),
`endif
        .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
        .o_busy(o_busy), .o_done(o_done),
        .o_mem_wrEnable(we), .o_mem_writeAdd(wa), .o_mem_readAdd(ra),
        .o_mem_data(wd), .i_mem_data(rd)
    );

    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd <= mem[ra];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: logs writes, output handshakes, done pulses; checks hold-during-stall.
    logic [9:0] wa_q[$];
    logic [7:0] wd_q[$];
    int         wc_q[$];
    logic [7:0] od_q[$];
    int         oc_q[$];
    int         done_cnt  = 0;
    int         done_cyc  = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev_data  = 8'h0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(o_rd_valid), 1);
                chk("stall_data", 32'(o_rd_data), 32'(prev_data));
            end
            if (we) begin
                wa_q.push_back(wa);
                wd_q.push_back(wd);
                wc_q.push_back(cyc);
            end
            if (o_rd_valid && i_rd_ready) begin
                od_q.push_back(o_rd_data);
                oc_q.push_back(cyc);
            end
            if (o_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            stall_prev <= o_rd_valid && !i_rd_ready;
            prev_data  <= o_rd_data;
        end
    end

    // Consumer: always ready, or random ready with 5-cycle stalls.
    int rdy_mode = 0;
    initial begin
        int stall_left;
        stall_left = 0;
        i_rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                i_rd_ready = 1'b1;
            end else if (stall_left > 0) begin
                i_rd_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 2) == 0) begin
                i_rd_ready = 1'b0;
                stall_left = 4;
            end else begin
                i_rd_ready = 1'b1;
            end
        end
    end

    logic [7:0] src[$];
    int wb, ob, db;

    task automatic set_bases();
        wb = wa_q.size();
        ob = od_q.size();
        db = done_cnt;
    endtask

    task automatic start_cmd(input int len);
        set_bases();
        i_start = 1'b1;
        i_len   = 10'(len);
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 1);
        chk("wr_ready_after_start", 32'(o_wr_ready), 1);
    endtask

    // Writes src; gaps insert an idle host cycle before odd words, poke pulses i_start in those gaps.
    task automatic write_src(input bit gaps, input bit poke);
        foreach (src[i]) begin
            if (gaps && i[0]) begin
                i_wr_valid = 1'b0;
                i_wr_data  = 8'hEE;
                i_start    = poke;
                i_len      = 10'd0;
                @(posedge clk); #1;
                i_start    = 1'b0;
            end
            i_wr_valid = 1'b1;
            i_wr_data  = src[i];
            @(posedge clk); #1;
        end
        i_wr_valid = 1'b0;
    endtask

    task automatic finish_frame(input int len, input bit exp_wr);
        int n;
        n = len + 1;
        for (int k = 0; k < n * 8 + 60; k++) begin
            if (done_cnt != db) break;
            @(posedge clk); #1;
        end
        chk("done_count", done_cnt - db, 1);
        chk("busy_after_done", 32'(o_busy), 0);
        chk("wr_count", wa_q.size() - wb, exp_wr ? n : 0);
        chk("out_count", od_q.size() - ob, n);
        if (exp_wr && (wa_q.size() - wb == n)) begin
            for (int i = 0; i < n; i++) begin
                chk("wr_addr", 32'(wa_q[wb + i]), i);
                chk("wr_data", 32'(wd_q[wb + i]), 32'(src[i]));
            end
        end
        if (od_q.size() - ob == n) begin
            for (int i = 0; i < n; i++) chk("out_data", 32'(od_q[ob + i]), 32'(src[i]));
            chk("done_with_last", done_cyc, oc_q[ob + len]);
        end
    endtask

    task automatic run_frame(input int len, input bit gaps, input bit poke);
        start_cmd(len);
        write_src(gaps, poke);
        if (poke) begin
            i_start = 1'b1;
            i_len   = 10'd0;
            @(posedge clk); #1;
            i_start = 1'b0;
        end
        finish_frame(len, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_ready"}, 32'(o_wr_ready), 0);
        chk({tag, "_rd_valid"}, 32'(o_rd_valid), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_rd_data"}, 32'(o_rd_data), 0);
        chk({tag, "_we"}, 32'(we), 0);
        chk({tag, "_wa"}, 32'(wa), 0);
        chk({tag, "_ra"}, 32'(ra), 0);
        chk({tag, "_wd"}, 32'(wd), 0);
    endtask

    initial begin
        i_start    = 1'b0;
        i_len      = 10'd0;
        i_wr_valid = 1'b0;
        i_wr_data  = 8'h0;
`ifdef MEM_CTRL_REPLAY_EN
        i_replay   = 1'b0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic 4-word frame: first output 3 cycles after last write, then back-to-back.
        src = {8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(3, 1'b0, 1'b0);
        if (oc_q.size() - ob == 4 && wc_q.size() - wb == 4) begin
            chk("first_out_latency", oc_q[ob] - wc_q[wb + 3], 3);
            chk("last_out_latency", oc_q[ob + 3] - wc_q[wb + 3], 6);
        end
        chk("basic_ra_end", 32'(ra), 4);
        chk("basic_wa_end", 32'(wa), 4);

`ifdef MEM_CTRL_REPLAY_EN
        set_bases();
        i_replay = 1'b1;
        @(posedge clk); #1;
        i_replay = 1'b0;
        chk("replay_busy", 32'(o_busy), 1);
        finish_frame(3, 1'b0);
`endif

        // Backpressure with random 5-cycle stalls.
        src = {};
        for (int i = 0; i < 8; i++) src.push_back(8'(i));
        rdy_mode = 1;
        run_frame(7, 1'b0, 1'b0);
        rdy_mode = 0;
        @(posedge clk); #1;

        // Single-word frame.
        src = {8'hA5};
        run_frame(0, 1'b0, 1'b0);

        // Host gaps plus ignored i_start in LOAD and RUN.
        src = {};
        for (int i = 0; i < 6; i++) src.push_back(8'(8'h60 + i));
        run_frame(5, 1'b1, 1'b1);

        // Full memory: counters wrap back to 0.
        src = {};
        for (int i = 0; i < 1024; i++) src.push_back(8'(i * 7 + 3));
        run_frame(1023, 1'b0, 1'b0);
        chk("full_ra_wrap", 32'(ra), 0);
        chk("full_wa_wrap", 32'(wa), 0);

        // Asynchronous reset after two of eight words leave.
        src = {};
        for (int i = 0; i < 8; i++) src.push_back(8'(8'hC0 + i));
        start_cmd(7);
        write_src(1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (od_q.size() - ob >= 2) break;
            @(posedge clk); #1;
        end
        chk("two_out_before_reset", od_q.size() - ob, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun");
        @(posedge clk); #1;
        rst_n = 1'b1;
        src = {8'h91, 8'h92, 8'h93, 8'h94};
        run_frame(3, 1'b0, 1'b0);

`ifdef MEM_CTRL_REPLAY_EN
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_replay = 1'b1;
        @(posedge clk); #1;
        i_replay = 1'b0;
        chk("replay_after_reset_busy", 32'(o_busy), 0);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
